// File: rtl/ram_4096_pkg.sv
// Shared types and sizing for the 4096 x 64 dual-port RAM.
package ram_4096_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 12;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] ram_data_t;
  typedef logic [ADDR_WIDTH-1:0] ram_addr_t;

endpackage : ram_4096_pkg

// File: rtl/ram_4096_if.sv
// Signal bundle between the RAM and whatever drives/observes it.
interface ram_if
  import ram_4096_pkg::*;
(
  input logic clk
);

  logic      rst_n;
  ram_data_t data_in;
  ram_addr_t wr_address;
  logic      write;
  ram_addr_t rd_address;
  logic      read;
  ram_data_t data_out;

  modport driver (
    input  clk,
    output rst_n, data_in, wr_address, write, rd_address, read,
    input  data_out
  );

  modport wr_mon (
    input clk, rst_n, data_in, wr_address, write
  );

  modport rd_mon (
    input clk, rst_n, rd_address, read, data_out
  );

  // Reset and clock reach the RAM as plain ports, so they are not listed here.
  modport duv (
    input  data_in, wr_address, write, rd_address, read,
    output data_out
  );

endinterface : ram_if

// File: rtl/ram_4096_array.sv
// Plain storage core: one write port, one registered read port, no reset,
// so synthesis can map it straight onto a block RAM.
module ram_4096_array
  import ram_4096_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_we,
  input  ram_addr_t i_wr_addr,
  input  ram_data_t i_wr_data,
  input  logic      i_re,
  input  ram_addr_t i_rd_addr,
  output ram_data_t o_rd_data
);

  ram_data_t r_mem [DEPTH];
  ram_data_t r_rd_data;

  // Write port: store the word on the rising edge when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port: non-blocking update gives read-before-write on an address clash.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule : ram_4096_array

// File: rtl/ram_4096.sv
// 4096 x 64 dual-port synchronous RAM with cleared-when-idle read data and
// asynchronous output reset. The array itself is never reset.
module ram_4096
  import ram_4096_pkg::*;
(
  input logic clk,
  input logic rst_n,
  ram_if.duv  bus
);

  logic      w_we;
  ram_data_t w_rd_data;
  logic      r_rd_vld;

  // Writes are dropped while reset is held so the array is frozen.
  assign w_we = bus.write & rst_n;

  ram_4096_array u_array (
    .i_clk     (clk),
    .i_we      (w_we),
    .i_wr_addr (bus.wr_address),
    .i_wr_data (bus.data_in),
    .i_re      (bus.read),
    .i_rd_addr (bus.rd_address),
    .o_rd_data (w_rd_data)
  );

  // Track whether the last edge performed a read; reset clears it at once,
  // which is what forces data_out to zero without touching the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_vld <= 1'b0;
    else        r_rd_vld <= bus.read;
  end

  assign bus.data_out = r_rd_vld ? w_rd_data : '0;

endmodule : ram_4096

// File: tb/tb_ram_4096.sv
// Directed and scoreboarded random checks for ram_4096.
module tb_ram_4096;
  import ram_4096_pkg::*;

  logic clk;
  int   n_checks;
  int   n_errors;
  ram_data_t mdl [int];

  ram_if bus (.clk(clk));

  ram_4096 dut (
    .clk   (clk),
    .rst_n (bus.rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input ram_data_t obs, input ram_data_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 ns after the rising edge.
  task automatic cyc(input logic w, input ram_addr_t wa, input ram_data_t d,
                     input logic r, input ram_addr_t ra);
    bus.write      = w;
    bus.wr_address = wa;
    bus.data_in    = d;
    bus.read       = r;
    bus.rd_address = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.rst_n = 1'b0;
    bus.write = 1'b0; bus.read = 1'b0;
    bus.wr_address = '0; bus.rd_address = '0; bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", bus.data_out, 64'h0);
    @(negedge clk);
    bus.rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write then read
    cyc(1, 12'h0A5, 64'hDEAD_BEEF_0123_4567, 0, 12'h000);
    chk("idle_after_wr", bus.data_out, 64'h0);
    cyc(0, 12'h000, 64'h0, 1, 12'h0A5);
    chk("wr_rd_0a5", bus.data_out, 64'hDEAD_BEEF_0123_4567);

    // Same-address collision: old data first, new data next edge
    cyc(1, 12'h007, 64'h1, 0, 12'h000);
    cyc(1, 12'h007, 64'h2, 1, 12'h007);
    chk("collide_old", bus.data_out, 64'h1);
    cyc(0, 12'h000, 64'h0, 1, 12'h007);
    chk("collide_new", bus.data_out, 64'h2);

    // Address boundaries, no aliasing
    cyc(1, 12'h000, 64'h1, 0, 12'h000);
    cyc(1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 12'h000);
    chk("addr0", bus.data_out, 64'h1);
    cyc(0, 12'h000, 64'h0, 1, 12'hFFF);
    chk("addr4095", bus.data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(0, 12'h000, 64'h0, 1, 12'h000);
    chk("addr0_again", bus.data_out, 64'h1);

    // Independent write and read at different addresses in one cycle
    cyc(1, 12'h123, 64'h0BAD_F00D_0000_0001, 1, 12'h0A5);
    chk("dual_port_rd", bus.data_out, 64'hDEAD_BEEF_0123_4567);
    cyc(0, 12'h000, 64'h0, 1, 12'h123);
    chk("dual_port_wr", bus.data_out, 64'h0BAD_F00D_0000_0001);

    // Idle: read deasserted clears output; write=0 leaves array untouched
    cyc(0, 12'h000, 64'h0, 0, 12'h123);
    chk("idle_clear", bus.data_out, 64'h0);
    for (int i = 0; i < 4; i++)
      cyc(0, 12'h0A5, {16{i[3:0]}}, 0, 12'h000);
    cyc(0, 12'h000, 64'h0, 1, 12'h0A5);
    chk("no_write_kept", bus.data_out, 64'hDEAD_BEEF_0123_4567);

    // Reset mid-burst
    cyc(1, 12'h005, 64'h5555_AAAA_1234_5678, 0, 12'h000);
    cyc(0, 12'h000, 64'h0, 1, 12'h005);
    chk("pre_reset_rd", bus.data_out, 64'h5555_AAAA_1234_5678);
    #2;
    bus.rst_n = 1'b0;
    #1;
    chk("reset_async", bus.data_out, 64'h0);
    cyc(1, 12'h005, 64'hFFFF_0000_FFFF_0000, 1, 12'h005);
    chk("reset_hold", bus.data_out, 64'h0);
    @(negedge clk);
    bus.rst_n = 1'b1;
    cyc(0, 12'h000, 64'h0, 1, 12'h005);
    chk("post_reset_rd", bus.data_out, 64'h5555_AAAA_1234_5678);
    cyc(0, 12'h000, 64'h0, 0, 12'h000);

    // Random traffic against a reference model
    for (int n = 0; n < 500; n++) begin
      logic      w, r, have;
      ram_addr_t wa, ra;
      ram_data_t d, exp;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 3) == 0) ? ram_addr_t'($urandom) : ram_addr_t'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : ram_addr_t'($urandom_range(0, 31));
      d  = {$urandom, $urandom};
      have = mdl.exists(int'(ra));
      exp  = have ? mdl[int'(ra)] : 64'h0;
      cyc(w, wa, d, r, ra);
      if (!r)
        chk("rand_idle", bus.data_out, 64'h0);
      else if (have)
        chk("rand_rd", bus.data_out, exp);
      if (w) mdl[int'(wa)] = d;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_4096
